// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory protocol.
// - funct3 width codes used on req_width
// - responder FSM state encoding
// - size / alignment decode helpers
package riscv_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_D  = 3'b011;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [2:0] MEM_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_HI   = 3'd2,
    ST_WR_HI   = 3'd3,
    ST_RESP    = 3'd4
  } resp_state_t;

  // Access size in bytes from funct3[1:0]; the sign bit does not affect size.
  function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
    case (size_code)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size_code);
    return 3'(size_bytes(size_code) - 4'd1);
  endfunction

endpackage

// File: rtl/data_ram_32.sv
// Single-port synchronous RAM, 32 bits wide with 4 byte enables.
// Ports:
//   clk   - clock
//   en    - access enable (read when we==0, write otherwise)
//   we    - byte write enables, bit n covers wdata[8n+7:8n]
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid the cycle after a read (1-cycle latency)
// No reset: contents survive a responder reset.
module data_ram_32 #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the data-memory protocol, backed by data_ram_32.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1; all request fields are captured on that edge.
// req_ready is 1 only in IDLE. resp_valid is a one-cycle pulse that carries
// either load data (data_fetched) or a store ack; resp_err qualifies it.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   req_*             - request channel (valid/ready, read/write, funct3,
//                       byte address, LSB-aligned store data)
//   resp_valid/err    - response pulse and error flag
//   data_fetched      - extended load data, held until the next response
//   dbg_state         - current FSM state (resp_state_t encoding)
module data_memory_responder
  import riscv_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read_en,
  input  logic        req_write_en,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_address,
  input  logic [63:0] req_write_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] data_fetched,
  output logic [2:0]  dbg_state
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  resp_state_t state, next_state;

  // Request decode (only meaningful in IDLE)
  logic [31:0]   offset;
  logic [AW-1:0] req_word;
  logic          misaligned, out_of_range, bad_cmd, req_err, accept;

  // Captured request
  logic          err_q;
  logic [2:0]    width_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] word_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  // RAM interface
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign offset       = req_address - BASE_ADDR;
  assign req_word     = offset[AW+1:2];
  assign misaligned   = |(req_address[2:0] & align_mask(req_width[1:0]));
  // Whole access must fit, so a doubleword never spills past the last word.
  assign out_of_range = ({1'b0, offset} + 33'(size_bytes(req_width[1:0]))) > SPAN_BYTES;
  assign bad_cmd      = (req_read_en == req_write_en) ||
                        (req_read_en && (req_width == 3'b111));
  assign req_err      = misaligned | out_of_range | bad_cmd;
  assign accept       = (state == ST_IDLE) && req_valid;

  function automatic logic [63:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  funct3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (funct3[1:0])
      2'b00:   return funct3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'b01:   return funct3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      default: return funct3[2] ? {32'd0, sh}       : {{32{sh[31]}}, sh};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    ram_addr   = word_q + AW'(1);
    ram_wdata  = hi_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            next_state = ST_RESP;
          end else if (req_write_en) begin
            ram_en   = 1'b1;
            ram_addr = req_word;
            case (req_width[1:0])
              2'b00: begin
                ram_we    = 4'b0001 << offset[1:0];
                ram_wdata = {4{req_write_data[7:0]}};
              end
              2'b01: begin
                ram_we    = 4'b0011 << offset[1:0];
                ram_wdata = {2{req_write_data[15:0]}};
              end
              default: begin
                ram_we    = 4'b1111;
                ram_wdata = req_write_data[31:0];
              end
            endcase
            next_state = (req_width[1:0] == 2'b11) ? ST_WR_HI : ST_RESP;
          end else begin
            ram_en     = 1'b1;
            ram_addr   = req_word;
            next_state = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (width_q[1:0] == 2'b11) begin
          ram_en     = 1'b1;
          next_state = ST_RD_HI;
        end else begin
          next_state = ST_RESP;
        end
      end
      ST_RD_HI: next_state = ST_RESP;
      ST_WR_HI: begin
        ram_en     = 1'b1;
        ram_we     = 4'b1111;
        next_state = ST_RESP;
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q        <= 1'b0;
      width_q      <= 3'd0;
      lane_q       <= 2'd0;
      word_q       <= '0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      data_fetched <= 64'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_q   <= req_err;
            width_q <= req_width;
            lane_q  <= offset[1:0];
            word_q  <= req_word;
            hi_q    <= req_write_data[63:32];
            if (req_err) data_fetched <= 64'd0;
          end
        end
        ST_RD_WAIT: begin
          if (width_q[1:0] == 2'b11) lo_q <= ram_rdata;
          else data_fetched <= extend_load(ram_rdata, lane_q, width_q);
        end
        ST_RD_HI: data_fetched <= {ram_rdata, lo_q};
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign dbg_state  = state;

  data_ram_32 #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed vector table, hand-written
// busy/reset sequences, and randomized accesses checked against a byte-array
// reference model.
module tb_data_memory_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          DW   = 1024;
  localparam int          SPAN = DW * 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_read_en, req_write_en;
  logic [2:0]  req_width;
  logic [31:0] req_address;
  logic [63:0] req_write_data;
  logic        resp_valid, resp_err;
  logic [63:0] data_fetched;
  logic [2:0]  dbg_state;

  data_memory_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read_en(req_read_en), .req_write_en(req_write_en),
    .req_width(req_width), .req_address(req_address),
    .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .data_fetched(data_fetched), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [SPAN];
  logic [63:0] last_m = 64'd0;

  task automatic model_access(input logic rd, input logic wr, input logic [2:0] w,
                              input logic [31:0] a, input logic [63:0] wd,
                              output logic err, output logic [63:0] data, output int lat);
    longint off;
    int size;
    logic [63:0] v;
    off  = longint'(a) - longint'(BASE);
    size = 1 << w[1:0];
    err  = (rd == wr) || (rd && w == 3'b111) || ((int'(a[2:0]) % size) != 0) ||
           (off < 0) || (off + size > SPAN);
    if (err) begin
      last_m = 64'd0;
      lat = 1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mem_m[int'(off) + i] = wd[8*i +: 8];
      lat = (size == 8) ? 2 : 1;
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[int'(off) + i];
      if (!w[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
      last_m = v;
      lat = (size == 8) ? 3 : 2;
    end
    data = last_m;
  endtask

  // ---------------- scoreboard ----------------
  // entry = {check_data, latency[3:0], err, data[63:0]}
  logic [69:0] exp_q[$];

  task automatic sb_compare(input string name, input logic e, input logic [63:0] d, input int l);
    logic [69:0] x;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb_empty got=response exp=queued_entry", name);
      return;
    end
    x = exp_q.pop_front();
    check64({name, "_lat"}, 64'(l), 64'(x[68:65]));
    check64({name, "_err"}, 64'(e), 64'(x[64]));
    if (x[69]) check64({name, "_data"}, d, x[63:0]);
  endtask

  // ---------------- driver ----------------
  // Entered and left on a negedge with the DUT back in IDLE.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] w,
                        input logic [31:0] a, input logic [63:0] wd,
                        output logic got_err, output logic [63:0] got_data, output int got_lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    req_valid = 1'b1; req_read_en = rd; req_write_en = wr;
    req_width = w; req_address = a; req_write_data = wd;
    @(posedge clk);
    #1;
    // Scramble fields: the DUT must have captured them at the edge.
    req_valid = 1'b0;
    req_read_en = 1'($urandom); req_write_en = 1'($urandom);
    req_width = 3'($urandom); req_address = $urandom;
    req_write_data = {$urandom, $urandom};
    got_lat = 0; got_err = 1'b0; got_data = 64'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got_lat = k; got_err = resp_err; got_data = data_fetched;
        break;
      end
    end
    @(negedge clk);
    check64("resp_pulse", 64'(resp_valid), 64'd0);
  endtask

  task automatic run_model_txn(input string name, input logic rd, input logic wr,
                               input logic [2:0] w, input logic [31:0] a, input logic [63:0] wd);
    logic me, ge;
    logic [63:0] md, gd;
    int ml, gl;
    model_access(rd, wr, w, a, wd, me, md, ml);
    exp_q.push_back({1'b1, 4'(ml), me, md});
    do_req(rd, wr, w, a, wd, ge, gd, gl);
    sb_compare(name, ge, gd, gl);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  w;
    logic [31:0] a;
    logic [63:0] wd;
    logic        exp_err;
    int          exp_lat;
    logic        chk;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(string nm, logic rd, logic wr, logic [2:0] w, logic [31:0] a,
                                  logic [63:0] wd, logic e, int l, logic c, logic [63:0] d);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.w = w; v.a = a; v.wd = wd;
    v.exp_err = e; v.exp_lat = l; v.chk = c; v.exp_data = d;
    vecs.push_back(v);
  endfunction

  initial begin
    logic me, ge;
    logic [63:0] md, gd;
    int ml, gl;
    int ready_low, resp_cnt;
    logic [63:0] busy_data;

    //     name          rd    wr    w       addr           wdata                   err  lat chk data
    add_vec("sw_w1",     1'b0, 1'b1, 3'b010, 32'h1001_0004, 64'h1234_5678_DEAD_BEEF, 1'b0, 1, 1'b1, 64'h0);
    add_vec("lw_w1",     1'b1, 1'b0, 3'b010, 32'h1001_0004, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF);
    add_vec("lwu_w1",    1'b1, 1'b0, 3'b110, 32'h1001_0004, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_DEAD_BEEF);
    add_vec("sw_w0",     1'b0, 1'b1, 3'b010, 32'h1001_0000, 64'h0000_0000_1122_3344, 1'b0, 1, 1'b1, 64'h0000_0000_DEAD_BEEF);
    add_vec("sb_b3",     1'b0, 1'b1, 3'b000, 32'h1001_0003, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 1'b0, 64'h0);
    add_vec("lb_b3",     1'b1, 1'b0, 3'b000, 32'h1001_0003, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    add_vec("lbu_b3",    1'b1, 1'b0, 3'b100, 32'h1001_0003, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_0000_0080);
    add_vec("lw_w0",     1'b1, 1'b0, 3'b010, 32'h1001_0000, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_8022_3344);
    add_vec("lhu_h1",    1'b1, 1'b0, 3'b101, 32'h1001_0002, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_0000_8022);
    add_vec("lh_h1",     1'b1, 1'b0, 3'b001, 32'h1001_0002, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_FFFF_8022);
    add_vec("lb_b0",     1'b1, 1'b0, 3'b000, 32'h1001_0000, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_0000_0044);
    add_vec("sd_w2",     1'b0, 1'b1, 3'b011, 32'h1001_0008, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 1'b1, 64'h0000_0000_0000_0044);
    add_vec("ld_w2",     1'b1, 1'b0, 3'b011, 32'h1001_0008, 64'h0, 1'b0, 3, 1'b1, 64'h0123_4567_89AB_CDEF);
    add_vec("lw_w2",     1'b1, 1'b0, 3'b010, 32'h1001_0008, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_89AB_CDEF);
    add_vec("lw_w3",     1'b1, 1'b0, 3'b010, 32'h1001_000C, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_0123_4567);
    add_vec("sd_last",   1'b0, 1'b1, 3'b011, 32'h1001_0FF8, 64'hFEDC_BA98_7654_3210, 1'b0, 2, 1'b0, 64'h0);
    add_vec("ld_last",   1'b1, 1'b0, 3'b011, 32'h1001_0FF8, 64'h0, 1'b0, 3, 1'b1, 64'hFEDC_BA98_7654_3210);
    add_vec("lh_mis",    1'b1, 1'b0, 3'b001, 32'h1001_0001, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("ld_mis",    1'b1, 1'b0, 3'b011, 32'h1001_0004, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("lw_below",  1'b1, 1'b0, 3'b010, 32'h1000_FFFC, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("sd_end",    1'b0, 1'b1, 3'b011, 32'h1001_0FFC, 64'h1111_1111_2222_2222, 1'b1, 1, 1'b1, 64'h0);
    add_vec("lw_above",  1'b1, 1'b0, 3'b010, 32'h1001_1000, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("rd_wr",     1'b1, 1'b1, 3'b010, 32'h1001_0000, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("no_op",     1'b0, 1'b0, 3'b010, 32'h1001_0000, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("rd_w111",   1'b1, 1'b0, 3'b111, 32'h1001_0008, 64'h0, 1'b1, 1, 1'b1, 64'h0);
    add_vec("ld_last2",  1'b1, 1'b0, 3'b011, 32'h1001_0FF8, 64'h0, 1'b0, 3, 1'b1, 64'hFEDC_BA98_7654_3210);
    add_vec("lw_w0_b",   1'b1, 1'b0, 3'b010, 32'h1001_0000, 64'h0, 1'b0, 2, 1'b1, 64'hFFFF_FFFF_8022_3344);
    add_vec("sh_hu",     1'b0, 1'b1, 3'b101, 32'h1001_0006, 64'h0000_0000_0000_5A5A, 1'b0, 1, 1'b1, 64'hFFFF_FFFF_8022_3344);
    add_vec("lw_w1_b",   1'b1, 1'b0, 3'b010, 32'h1001_0004, 64'h0, 1'b0, 2, 1'b1, 64'h0000_0000_5A5A_BEEF);
    add_vec("sd_w111",   1'b0, 1'b1, 3'b111, 32'h1001_0010, 64'hCAFE_F00D_1234_5678, 1'b0, 2, 1'b0, 64'h0);
    add_vec("ld_w4",     1'b1, 1'b0, 3'b011, 32'h1001_0010, 64'h0, 1'b0, 3, 1'b1, 64'hCAFE_F00D_1234_5678);

    rst = 1'b0; req_valid = 1'b0; req_read_en = 1'b0; req_write_en = 1'b0;
    req_width = 3'd0; req_address = 32'd0; req_write_data = 64'd0;
    repeat (2) @(negedge clk);
    check64("rst_ready", 64'(req_ready), 64'd1);
    check64("rst_resp_valid", 64'(resp_valid), 64'd0);
    check64("rst_resp_err", 64'(resp_err), 64'd0);
    check64("rst_data", data_fetched, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      model_access(v.rd, v.wr, v.w, v.a, v.wd, me, md, ml);
      exp_q.push_back({v.chk, 4'(v.exp_lat), v.exp_err, v.exp_data});
      do_req(v.rd, v.wr, v.w, v.a, v.wd, ge, gd, gl);
      sb_compare(v.name, ge, gd, gl);
    end

    // Busy period: req_valid stays high across an LD.
    req_valid = 1'b1; req_read_en = 1'b1; req_write_en = 1'b0;
    req_width = 3'b011; req_address = 32'h1001_0008; req_write_data = 64'd0;
    model_access(1'b1, 1'b0, 3'b011, 32'h1001_0008, 64'd0, me, md, ml);
    @(posedge clk);
    ready_low = 0; resp_cnt = 0; busy_data = 64'd0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (!req_ready) ready_low++;
      if (resp_valid) begin
        resp_cnt++;
        busy_data = data_fetched;
      end
    end
    @(negedge clk);
    check64("busy_ready_back", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) resp_cnt++;
    end
    check64("busy_ready_low_cycles", 64'(ready_low), 64'd3);
    check64("busy_resp_count", 64'(resp_cnt), 64'd1);
    check64("busy_data", busy_data, 64'h0123_4567_89AB_CDEF);

    // Reset one cycle after an SD is accepted: only the low word lands.
    run_model_txn("sd_pre", 1'b0, 1'b1, 3'b011, 32'h1001_0020, 64'hAAAA_AAAA_5555_5555);
    req_valid = 1'b1; req_read_en = 1'b0; req_write_en = 1'b1;
    req_width = 3'b011; req_address = 32'h1001_0020; req_write_data = 64'h1111_2222_3333_4444;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check64("mid_rst_ready", 64'(req_ready), 64'd1);
    check64("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check64("mid_rst_resp_err", 64'(resp_err), 64'd0);
    check64("mid_rst_data", data_fetched, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_m[32'h20] = 8'h44; mem_m[32'h21] = 8'h44; mem_m[32'h22] = 8'h33; mem_m[32'h23] = 8'h33;
    last_m = 64'd0;
    run_model_txn("ld_after_rst", 1'b1, 1'b0, 3'b011, 32'h1001_0020, 64'd0);

    // Fill the regions used by random traffic so every read is defined.
    for (int off = 0; off < 64; off += 8)
      run_model_txn("init_lo", 1'b0, 1'b1, 3'b011, BASE + 32'(off), {$urandom, $urandom});
    run_model_txn("init_hi", 1'b0, 1'b1, 3'b011, BASE + 32'(SPAN - 8), {$urandom, $urandom});

    // Randomized traffic against the model.
    for (int n = 0; n < 160; n++) begin
      logic rd, wr;
      logic [2:0] w;
      logic [31:0] a;
      int sel, off, op;
      w   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel < 7)      off = $urandom_range(0, 63);
      else if (sel < 9) off = SPAN - 8 + $urandom_range(0, 7);
      else              off = $urandom_range(SPAN, SPAN + 64);
      if ($urandom_range(0, 1) == 1) off = off & ~((1 << w[1:0]) - 1);
      a = BASE + 32'(off);
      if (sel == 9 && $urandom_range(0, 1) == 1) a = BASE - 32'($urandom_range(1, 16));
      op = $urandom_range(0, 15);
      if (op == 0)      begin rd = 1'b1; wr = 1'b1; end
      else if (op == 1) begin rd = 1'b0; wr = 1'b0; end
      else              begin rd = op[0]; wr = ~op[0]; end
      run_model_txn("rand", rd, wr, w, a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    check64("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
